// File: rtl/iob_2p_assim_afifo_wr_ctrl_w_big.sv
`default_nettype none
// ============================================================================
// Module   : iob_2p_assim_afifo_wr_ctrl_w_big
// Purpose  : Write-side controller for an asymmetric async FIFO. The write word
//            is RATIO times wider than the read word. The controller accepts
//            pushes and drives the memory write port (enable, data, Gray word
//            address). It synchronizes the read pointer from the read domain
//            and reports full, almost-full, fill level and sticky overflow.
//            It exports its registered Gray write pointer for the read-side
//            synchronizer.
// Ports    : clk, rst      - write-domain clock, synchronous active-high reset
//            w_en, data_in - push request and push data (W_DATA_W)
//            r_ptr_gray    - read pointer, Gray, narrow-word units (async)
//            mem_w_en, mem_data, mem_w_addr - memory write port
//            w_ptr_gray    - Gray write pointer, wide-word units, registered
//            full, almost_full, level, overflow - status
// Revision : 1.0 - initial release
// ============================================================================
module iob_2p_assim_afifo_wr_ctrl_w_big #(
  parameter int W_DATA_W = 16,
  parameter int R_DATA_W = 8,
  parameter int W_ADDR_W = 6,
  parameter int AF_LEVEL = 60,
  localparam int RATIO    = W_DATA_W / R_DATA_W,
  localparam int LOG2R    = $clog2(RATIO),
  localparam int R_ADDR_W = W_ADDR_W + LOG2R
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_en,
  input  logic [W_DATA_W-1:0] data_in,
  input  logic [R_ADDR_W:0]   r_ptr_gray,
  output logic                mem_w_en,
  output logic [W_DATA_W-1:0] mem_data,
  output logic [W_ADDR_W-1:0] mem_w_addr,
  output logic [W_ADDR_W:0]   w_ptr_gray,
  output logic                full,
  output logic                almost_full,
  output logic [W_ADDR_W:0]   level,
  output logic                overflow
);

  localparam logic [W_ADDR_W:0] ONE_W      = (W_ADDR_W+1)'(1);
  localparam logic [W_ADDR_W:0] FULL_LEVEL = (W_ADDR_W+1)'(1 << W_ADDR_W);
  localparam logic [W_ADDR_W:0] AF_THRESH  = (W_ADDR_W+1)'(AF_LEVEL);

  logic [W_ADDR_W:0]   wptr;
  logic [W_ADDR_W:0]   wptr_next;
  logic [R_ADDR_W:0]   rp_sync1;
  logic [R_ADDR_W:0]   rp_sync2;
  logic [W_ADDR_W:0]   rp_w;
  logic [W_ADDR_W-1:0] wptr_low;
  logic                accept;

  // Gray-to-binary conversion of only the bits that survive the narrow-to-wide
  // shift. Binary bit k is the XOR of all Gray bits at or above k. Dropping
  // the low LOG2R bits floors the pointer. A wide slot is therefore released
  // only after every narrow word in it has been read.
  always_comb begin
    rp_w = '0;
    for (int i = 0; i <= W_ADDR_W; i++) begin
      rp_w[i] = ^(rp_sync2 >> (i + LOG2R));
    end
  end

  // Status depends only on flops. The extra MSB of both pointers tells a
  // full FIFO apart from an empty one.
  assign level       = wptr - rp_w;
  assign full        = (level == FULL_LEVEL);
  assign almost_full = (level >= AF_THRESH);

  assign accept   = w_en & ~full;
  assign mem_w_en = accept;
  assign mem_data = data_in;

  // The memory is addressed in Gray code. The address comes from the
  // registered pointer only, so there is no path from the inputs to the
  // address.
  assign wptr_low   = wptr[W_ADDR_W-1:0];
  assign mem_w_addr = wptr_low ^ (wptr_low >> 1);

  assign wptr_next = wptr + ONE_W;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rp_sync1   <= '0;
      rp_sync2   <= '0;
      w_ptr_gray <= '0;
      overflow   <= 1'b0;
    end else begin
      rp_sync1 <= r_ptr_gray;
      rp_sync2 <= rp_sync1;
      if (accept) begin
        wptr       <= wptr_next;
        // The exported Gray pointer is registered from the next binary value.
        // It changes in at most one bit per cycle.
        w_ptr_gray <= wptr_next ^ (wptr_next >> 1);
      end
      if (w_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iob_2p_assim_afifo_wr_ctrl_w_big.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_2p_assim_afifo_wr_ctrl_w_big
// Purpose  : Directed self-checking bench for the asymmetric FIFO write
//            controller, using default parameters (RATIO=2, depth 64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_iob_2p_assim_afifo_wr_ctrl_w_big;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_en;
  logic [15:0] data_in;
  logic [7:0]  r_ptr_gray;
  logic        mem_w_en;
  logic [15:0] mem_data;
  logic [5:0]  mem_w_addr;
  logic [6:0]  w_ptr_gray;
  logic        full;
  logic        almost_full;
  logic [6:0]  level;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  iob_2p_assim_afifo_wr_ctrl_w_big dut (
    .clk         (clk),
    .rst         (rst),
    .w_en        (w_en),
    .data_in     (data_in),
    .r_ptr_gray  (r_ptr_gray),
    .mem_w_en    (mem_w_en),
    .mem_data    (mem_data),
    .mem_w_addr  (mem_w_addr),
    .w_ptr_gray  (w_ptr_gray),
    .full        (full),
    .almost_full (almost_full),
    .level       (level),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] g6(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [6:0] g7(input logic [6:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [7:0] g8(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  // Advance one cycle and settle 1 ns after the edge. Stimulus and checks
  // both happen here, away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; w_en = 1'b0; data_in = '0; r_ptr_gray = '0;
    tick(); tick();
    checks++; if (level !== 7'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got=%b exp=0", almost_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    checks++; if (mem_w_addr !== 6'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", mem_w_addr); end
    checks++; if (w_ptr_gray !== 7'd0) begin errors++; $display("FAIL reset_wgray got=%0h exp=0", w_ptr_gray); end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [6:0] idx;
    for (int i = 0; i < 64; i++) begin
      idx = 7'(i);
      w_en = 1'b1; data_in = 16'h1000 + 16'(i);
      #1;
      checks++; if (mem_w_en !== 1'b1) begin errors++; $display("FAIL fill_wen i=%0d got=%b exp=1", i, mem_w_en); end
      checks++; if (mem_data !== 16'h1000 + 16'(i)) begin errors++; $display("FAIL fill_data i=%0d got=%0h exp=%0h", i, mem_data, 16'h1000 + 16'(i)); end
      checks++; if (mem_w_addr !== g6(idx[5:0])) begin errors++; $display("FAIL fill_addr i=%0d got=%0h exp=%0h", i, mem_w_addr, g6(idx[5:0])); end
      checks++; if (level !== idx) begin errors++; $display("FAIL fill_level i=%0d got=%0d exp=%0d", i, level, idx); end
      checks++; if (almost_full !== (i >= 60)) begin errors++; $display("FAIL fill_af i=%0d got=%b exp=%b", i, almost_full, (i >= 60)); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_full i=%0d got=%b exp=0", i, full); end
      checks++; if (w_ptr_gray !== g7(idx)) begin errors++; $display("FAIL fill_wgray i=%0d got=%0h exp=%0h", i, w_ptr_gray, g7(idx)); end
      tick();
    end
    w_en = 1'b0;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_after64 got=%b exp=1", full); end
    checks++; if (level !== 7'd64) begin errors++; $display("FAIL level_after64 got=%0d exp=64", level); end
    checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL af_after64 got=%b exp=1", almost_full); end
    checks++; if (w_ptr_gray !== 7'h60) begin errors++; $display("FAIL wgray_after64 got=%0h exp=60", w_ptr_gray); end
    checks++; if (mem_w_addr !== 6'd0) begin errors++; $display("FAIL addr_after64 got=%0h exp=0", mem_w_addr); end
  endtask

  task automatic test_overflow();
    w_en = 1'b1; data_in = 16'hBEEF;
    #1;
    checks++; if (mem_w_en !== 1'b0) begin errors++; $display("FAIL ovf_wen got=%b exp=0", mem_w_en); end
    tick();
    w_en = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    checks++; if (w_ptr_gray !== 7'h60) begin errors++; $display("FAIL ovf_wgray got=%0h exp=60", w_ptr_gray); end
    checks++; if (level !== 7'd64) begin errors++; $display("FAIL ovf_level got=%0d exp=64", level); end
    tick(); tick(); tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_read_release();
    // One narrow read does not free a wide slot.
    r_ptr_gray = g8(8'd1);
    tick(); tick(); tick();
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL half_read_full got=%b exp=1", full); end
    checks++; if (level !== 7'd64) begin errors++; $display("FAIL half_read_level got=%0d exp=64", level); end
    // The second narrow read frees one wide slot, visible after two edges.
    r_ptr_gray = g8(8'd2);
    tick();
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL release_1cyc_full got=%b exp=1", full); end
    tick();
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL release_2cyc_full got=%b exp=0", full); end
    checks++; if (level !== 7'd63) begin errors++; $display("FAIL release_2cyc_level got=%0d exp=63", level); end
  endtask

  task automatic test_random();
    logic [6:0] wp;
    logic [7:0] rn, rn_d1, rn_d2;
    logic [6:0] exp_lvl, prev_gray;
    logic       exp_full, push;
    wp = 7'd64; rn = 8'd2; rn_d1 = 8'd2; rn_d2 = 8'd2; prev_gray = g7(wp);
    for (int c = 0; c < 300; c++) begin
      push = ($urandom_range(0, 99) < 55);
      w_en = push; data_in = 16'($urandom);
      #1;
      exp_lvl  = wp - 7'(rn_d2 >> 1);
      exp_full = (exp_lvl == 7'd64);
      checks++; if (level !== exp_lvl) begin errors++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, level, exp_lvl); end
      checks++; if (full !== exp_full) begin errors++; $display("FAIL rnd_full c=%0d got=%b exp=%b", c, full, exp_full); end
      checks++; if (almost_full !== (exp_lvl >= 7'd60)) begin errors++; $display("FAIL rnd_af c=%0d got=%b exp=%b", c, almost_full, (exp_lvl >= 7'd60)); end
      checks++; if (mem_w_en !== (push && !exp_full)) begin errors++; $display("FAIL rnd_wen c=%0d got=%b exp=%b", c, mem_w_en, (push && !exp_full)); end
      checks++; if (mem_w_addr !== g6(wp[5:0])) begin errors++; $display("FAIL rnd_addr c=%0d got=%0h exp=%0h", c, mem_w_addr, g6(wp[5:0])); end
      checks++; if (w_ptr_gray !== g7(wp)) begin errors++; $display("FAIL rnd_wgray c=%0d got=%0h exp=%0h", c, w_ptr_gray, g7(wp)); end
      checks++; if ($countones(w_ptr_gray ^ prev_gray) > 1) begin errors++; $display("FAIL rnd_gray_step c=%0d got=%0h prev=%0h exp=single-bit step", c, w_ptr_gray, prev_gray); end
      prev_gray = w_ptr_gray;
      tick();
      if (push && !exp_full) wp = wp + 7'd1;
      rn_d2 = rn_d1; rn_d1 = rn;
      // The reader advances one narrow word at a time and never passes the
      // writer in wide units.
      if ((7'(wp - 7'(rn >> 1)) != 7'd0) && ($urandom_range(0, 99) < 90)) rn = rn + 8'd1;
      r_ptr_gray = g8(rn);
    end
    w_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; r_ptr_gray = '0; w_en = 1'b0;
    tick();
    rst = 1'b0;
    w_en = 1'b1;
    for (int i = 0; i < 65; i++) tick();  // 64 writes plus one rejected push
    w_en = 1'b0;
    r_ptr_gray = g8(8'd108);              // 54 wide words read -> level 10
    tick(); tick();
    checks++; if (level !== 7'd10) begin errors++; $display("FAIL mid_pre_level got=%0d exp=10", level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL mid_pre_ovf got=%b exp=1", overflow); end
    rst = 1'b1; w_en = 1'b1; data_in = 16'hA5A5;
    #1;
    checks++; if (mem_w_en !== 1'b1) begin errors++; $display("FAIL mid_rst_wen got=%b exp=1", mem_w_en); end
    tick();
    rst = 1'b0; w_en = 1'b0; r_ptr_gray = '0;
    checks++; if (level !== 7'd0) begin errors++; $display("FAIL mid_level got=%0d exp=0", level); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL mid_full got=%b exp=0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf got=%b exp=0", overflow); end
    checks++; if (w_ptr_gray !== 7'd0) begin errors++; $display("FAIL mid_wgray got=%0h exp=0", w_ptr_gray); end
    checks++; if (mem_w_addr !== 6'd0) begin errors++; $display("FAIL mid_addr got=%0h exp=0", mem_w_addr); end
  endtask

  initial begin
    rst = 1'b1; w_en = 1'b0; data_in = '0; r_ptr_gray = '0;
    #1;
    test_reset();
    test_back_to_back();
    test_overflow();
    test_read_release();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
